// File: rtl/inst_fetch.sv
// Instruction fetch stage: holds the fetch PC, reads the combinational
// instruction memory, and buffers {pc, inst} pairs in a small FIFO for decode.
//
// Handshake (decode side): an entry transfers on a rising edge where
// out_valid && out_ready. out_valid depends only on registered occupancy,
// never on out_ready, and out_inst/out_pc are stable while out_valid is held
// without out_ready. A redirect flushes the FIFO; a pop on the same edge is
// still treated as accepted by decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          CNT_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_pc,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic push;
  logic pop;
  logic full;

  // Handshake and occupancy decode from registered state
  always_comb begin
    full      = (cnt_q == CNT_W'(DEPTH));
    out_valid = (cnt_q != '0);
    pop       = out_valid & out_ready;
    push      = ~redirect_valid & (~full | pop);
    imem_addr = {2'b00, fetch_pc[31:2]};
    out_inst  = inst_mem[rd_ptr];
    out_pc    = pc_mem[rd_ptr];
    count     = cnt_q;
  end

  // PC, pointers, occupancy and FIFO storage; reset beats redirect beats handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        inst_mem[wr_ptr] <= imem_data;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a table of directed vectors, hand-written corner
// sequences, and random stimulus, all scored against a queue-based model.
module tb_inst_fetch;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_inst;
  logic [31:0]      out_pc;
  logic [CNT_W-1:0] count;

  inst_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .count(count)
  );

  // Instruction memory contents: fixed words 0..3, hashed elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h13;
      32'd1:   return 32'h93;
      32'd2:   return 32'h113;
      32'd3:   return 32'h193;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];     // {pc, inst}, head at index 0
  logic [31:0] model_pc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // One rising edge as seen by the fetch stage's rules
  task automatic model_edge(input logic r_n, input logic redir,
                            input logic [31:0] rpc, input logic rdy);
    bit did_pop;
    if (!r_n) begin
      exp_q.delete();
      model_pc = 32'h0;
    end else if (redir) begin
      exp_q.delete();
      model_pc = {rpc[31:2], 2'b00};
    end else begin
      did_pop = (exp_q.size() > 0) && rdy;
      if (did_pop) void'(exp_q.pop_front());
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back({model_pc, mem_word(model_pc >> 2)});
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
    chk({tag, ".count"}, {30'b0, count}, 32'(exp_q.size()));
    chk({tag, ".addr"}, imem_addr, model_pc >> 2);
    if (exp_q.size() != 0) begin
      chk({tag, ".pc"}, out_pc, exp_q[0][63:32]);
      chk({tag, ".inst"}, out_inst, exp_q[0][31:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r_n, input logic redir,
                      input logic [31:0] rpc, input logic rdy, input string tag);
    rst_n = r_n;
    redirect_valid = redir;
    redirect_pc = rpc;
    out_ready = rdy;
    @(posedge clk);
    model_edge(r_n, redir, rpc, rdy);
    #1;
    compare_model(tag);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        r_n;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_count;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r_n, input logic redir, input logic [31:0] rpc,
                         input logic rdy, input logic ev, input logic [1:0] ec,
                         input logic [31:0] ea, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.r_n = r_n; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_count = ec; v.e_addr = ea; v.e_pc = ep; v.e_inst = ei;
    vecs.push_back(v);
  endtask

  initial begin
    // free run from reset
    add_vec(0, 0, 0, 1,  0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1,  1, 1, 1, 32'h0, 32'h13);
    add_vec(1, 0, 0, 1,  1, 1, 2, 32'h4, 32'h93);
    add_vec(1, 0, 0, 1,  1, 1, 3, 32'h8, 32'h113);
    add_vec(1, 0, 0, 1,  1, 1, 4, 32'hC, 32'h193);
    // backpressure from reset, then full with simultaneous pop/push
    add_vec(0, 0, 0, 0,  0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0,  1, 1, 1, 32'h0, 32'h13);
    add_vec(1, 0, 0, 0,  1, 2, 2, 32'h0, 32'h13);
    add_vec(1, 0, 0, 0,  1, 2, 2, 32'h0, 32'h13);
    add_vec(1, 0, 0, 1,  1, 2, 3, 32'h4, 32'h93);
    add_vec(1, 0, 0, 1,  1, 2, 4, 32'h8, 32'h113);
    // redirect while full: unaligned target, low bits dropped
    add_vec(1, 1, 32'h16, 0,  0, 0, 5, 0, 0);
    add_vec(1, 0, 0, 0,  1, 1, 6, 32'h14, mem_word(32'd5));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r_n, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("tbl%0d.count", i), {30'b0, count}, {30'b0, vecs[i].e_count});
      chk($sformatf("tbl%0d.addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        chk($sformatf("tbl%0d.pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("tbl%0d.inst", i), out_inst, vecs[i].e_inst);
      end
    end

    // reset mid-operation with full FIFO and a competing redirect
    step(1, 1, 32'h38, 0, "rst_mid.redir");
    step(1, 0, 0, 0, "rst_mid.fill1");
    step(1, 0, 0, 0, "rst_mid.fill2");
    chk("rst_mid.pre_count", {30'b0, count}, 32'd2);
    chk("rst_mid.pre_addr", imem_addr, 32'h10);
    step(0, 1, 32'h100, 1, "rst_mid.reset");
    chk("rst_mid.count", {30'b0, count}, 32'd0);
    chk("rst_mid.valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid.addr", imem_addr, 32'd0);
    chk("rst_mid.ram_pc", out_pc, 32'd0);

    // PC wrap at the top of the address space
    step(1, 1, 32'hFFFF_FFFC, 1, "wrap.redir");
    chk("wrap.addr", imem_addr, 32'h3FFF_FFFF);
    step(1, 0, 0, 1, "wrap.s1");
    chk("wrap.pc0", out_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 1, "wrap.s2");
    chk("wrap.pc1", out_pc, 32'h0000_0000);
    chk("wrap.inst1", out_inst, 32'h13);
    step(1, 0, 0, 1, "wrap.s3");
    chk("wrap.pc2", out_pc, 32'h0000_0004);

    // back-to-back redirects: last one wins
    step(1, 1, 32'h200, 0, "b2b.r1");
    step(1, 1, 32'h301, 0, "b2b.r2");
    chk("b2b.addr", imem_addr, 32'hC0);
    step(1, 0, 0, 0, "b2b.push");
    chk("b2b.pc", out_pc, 32'h300);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 40) != 0,
           $urandom_range(0, 9) == 0,
           $urandom,
           $urandom_range(0, 2) != 0,
           $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
